// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-addressed register bank.
// Holds the controller state encoding, the frame width derivation and the R/W bit values.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_FLUSH
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an SPI master and the register bank (mode 0, nCS active-low).
interface spi_reg_bank_if;
    logic COPI;
    logic SCLK;
    logic nCS;
    logic CIPO;
    logic cipo_oe;

    modport master (output COPI, output SCLK, output nCS, input CIPO, input cipo_oe);
    modport slave  (input COPI, input SCLK, input nCS, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for one asynchronous input with rise/fall detection.
// Edges are detected between stages 2 and 3; the level output is stage 3.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[2];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank written and read over a mode-0 SPI slave port, oversampled by clk.
// Frame: R/W bit, address, data, MSB first; writes commit only when nCS rises on a complete frame.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_reg_bank_if.slave                spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         err_frame
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi.SCLK),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(spi.COPI),
        .dout(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(spi.nCS),
        .dout(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Only the sampled COPI level and the SCLK edges drive the protocol.
    logic unused_sync;
    assign unused_sync = ^{copi_rise, copi_fall, sclk_lvl};

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-1:0]     shin_q, shin_d;
    logic [DATA_W-1:0]      shout_q, shout_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
    logic                   err_q, err_d;

    logic [ADDR_W-1:0]      cmd_addr;
    logic [DATA_W-1:0]      rd_val;
    logic                   frame_rw;
    logic [ADDR_W-1:0]      frame_addr;
    logic [DATA_W-1:0]      frame_data;
    logic                   frame_addr_ok;

    assign cmd_addr      = shin_q[ADDR_W-1:0];
    assign frame_rw      = shin_q[FRAME_W-1];
    assign frame_addr    = shin_q[DATA_W +: ADDR_W];
    assign frame_data    = shin_q[DATA_W-1:0];
    assign frame_addr_ok = int'(frame_addr) < NUM_REGS;

    // Unimplemented addresses read back as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        err_d       = 1'b0;

        if (ncs_fall) begin
            cnt_d = '0;
        end else if (sclk_rise && !ncs_lvl && cnt_q != CNT_MAX) begin
            cnt_d  = cnt_q + 1'b1;
            shin_d = {shin_q[FRAME_W-2:0], copi_lvl};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cnt_q == CNT_CMD) begin
                    if (shin_q[ADDR_W] == RW_READ) begin
                        state_d = ST_RD_DATA;
                        shout_d = rd_val;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
            end
            // The fall that follows the last address bit must not shift, or the MSB is lost.
            ST_RD_DATA: begin
                if (sclk_fall && cnt_q > CNT_CMD) begin
                    shout_d = shout_q << 1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                if (cnt_q == CNT_FULL && frame_addr_ok) begin
                    if (frame_rw == RW_WRITE) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (frame_addr == ADDR_W'(i)) begin
                                regs_d[i]      = frame_data;
                                wr_strobe_d[i] = 1'b1;
                            end
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ncs_rise) begin
            state_d = ST_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            regs_q      <= '{default: '0};
            wr_strobe_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign spi.cipo_oe = (state_q == ST_RD_DATA);
    assign spi.CIPO    = (state_q == ST_RD_DATA) & shout_q[DATA_W-1];
    assign wr_strobe   = wr_strobe_q;
    assign err_frame   = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: default instance plus a 16x16-bit, 4-bit-address instance.
// Stimulus pushes expected write/error/read events; monitors pop and compare as the DUTs emit them.
module tb_spi_reg_bank;

    localparam int K_WR  = 0;
    localparam int K_ERR = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } evt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       copi;
    logic       sclk;
    logic [1:0] ncs;

    spi_reg_bank_if if0();
    spi_reg_bank_if if1();

    assign if0.COPI = copi;
    assign if0.SCLK = sclk;
    assign if0.nCS  = ncs[0];
    assign if1.COPI = copi;
    assign if1.SCLK = sclk;
    assign if1.nCS  = ncs[1];

    logic [39:0]  regs0;
    logic [4:0]   wr0;
    logic         err0;
    logic [255:0] regs1;
    logic [15:0]  wr1;
    logic         err1;

    spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi(if0),
        .regs_out(regs0), .wr_strobe(wr0), .err_frame(err0)
    );

    spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .spi(if1),
        .regs_out(regs1), .wr_strobe(wr1), .err_frame(err1)
    );

    evt_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic observe(input int dut, input int kind, input logic [31:0] a, input logic [31:0] b);
        evt_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_event: dut %0d kind %0d a=0x%0h b=0x%0h, expected no event",
                     dut, kind, a, b);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("evt_source(dut*4+kind)"), 64'(dut * 4 + kind), 64'(e.dut * 4 + e.kind));
            check($sformatf("evt_a dut%0d kind%0d", dut, kind), 64'(a), 64'(e.a));
            check($sformatf("evt_b dut%0d kind%0d", dut, kind), 64'(b), 64'(e.b));
        end
    endtask

    // CIPO capture on the master's sampling edge.
    logic [31:0] acc0 = '0, acc1 = '0;
    int          nb0 = 0, nb1 = 0;

    initial begin
        forever begin
            @(posedge sclk);
            if (if0.cipo_oe) begin
                acc0 = {acc0[30:0], if0.CIPO};
                nb0++;
            end
            if (if1.cipo_oe) begin
                acc1 = {acc1[30:0], if1.CIPO};
                nb1++;
            end
        end
    end

    function automatic logic [31:0] low_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    logic        oe0_prev = 1'b0, oe1_prev = 1'b0;
    int          base0 = 0, base1 = 0;
    logic [31:0] v0, v1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr0 != '0) begin
                    v0 = '0;
                    for (int i = 0; i < 5; i++) if (wr0[i]) v0 = 32'(regs0[i*8 +: 8]);
                    observe(0, K_WR, 32'(wr0), v0);
                end
                if (err0) observe(0, K_ERR, 32'h0, 32'h0);
                if (!oe0_prev && if0.cipo_oe) base0 = nb0;
                if (oe0_prev && !if0.cipo_oe)
                    observe(0, K_RD, 32'(nb0 - base0), acc0 & low_mask(nb0 - base0));

                if (wr1 != '0) begin
                    v1 = '0;
                    for (int i = 0; i < 16; i++) if (wr1[i]) v1 = 32'(regs1[i*16 +: 16]);
                    observe(1, K_WR, 32'(wr1), v1);
                end
                if (err1) observe(1, K_ERR, 32'h0, 32'h0);
                if (!oe1_prev && if1.cipo_oe) base1 = nb1;
                if (oe1_prev && !if1.cipo_oe)
                    observe(1, K_RD, 32'(nb1 - base1), acc1 & low_mask(nb1 - base1));
            end
            oe0_prev = if0.cipo_oe;
            oe1_prev = if1.cipo_oe;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: COPI set while SCLK low, 8 clk per SCLK phase.
    task automatic xfer(input int sel, input int nbits, input logic [31:0] frame, input bit hold_cs);
        ncs[sel] = 1'b0;
        wait_clk(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = frame[i];
            wait_clk(8);
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
        if (!hold_cs) begin
            ncs[sel] = 1'b1;
            wait_clk(12);
        end
    endtask

    task automatic expect_evt(input int dut, input int kind, input logic [31:0] a, input logic [31:0] b);
        evt_t e;
        e.dut  = dut;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regs0"}, 64'(regs0), 64'h0);
        check({tag, "_wr0"}, 64'(wr0), 64'h0);
        check({tag, "_err0"}, 64'(err0), 64'h0);
        check({tag, "_cipo0"}, 64'(if0.CIPO), 64'h0);
        check({tag, "_oe0"}, 64'(if0.cipo_oe), 64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        copi  = 1'b0;
        sclk  = 1'b0;
        ncs   = 2'b11;
        wait_clk(3);
        check_reset_outputs("reset");
        check("reset_regs1_top", 64'(regs1[255:192]), 64'h0);
        rst_n = 1'b1;
        wait_clk(6);

        expect_evt(0, K_WR, 32'h04, 32'hA5);
        xfer(0, 16, 32'h82A5, 1'b0);
        check("wr_a5_regs", 64'(regs0), 64'h00_00_A5_00_00);

        expect_evt(0, K_RD, 32'd8, 32'hA5);
        xfer(0, 16, 32'h0200, 1'b0);
        check("rd_a5_regs_hold", 64'(regs0), 64'h00_00_A5_00_00);

        expect_evt(0, K_ERR, 32'h0, 32'h0);
        xfer(0, 16, 32'h86FF, 1'b0);
        check("bad_addr_regs_hold", 64'(regs0), 64'h00_00_A5_00_00);

        expect_evt(0, K_ERR, 32'h0, 32'h0);
        xfer(0, 10, 32'h8133 >> 6, 1'b0);
        check("abort_reg1_hold", 64'(regs0[15:8]), 64'h0);

        expect_evt(0, K_ERR, 32'h0, 32'h0);
        xfer(0, 17, 32'h8133 << 1, 1'b0);
        check("long_frame_regs_hold", 64'(regs0), 64'h00_00_A5_00_00);

        expect_evt(0, K_WR, 32'h02, 32'h33);
        xfer(0, 16, 32'h8133, 1'b0);
        expect_evt(0, K_WR, 32'h10, 32'h5A);
        xfer(0, 16, 32'h845A, 1'b0);
        check("wr_33_5a_regs", 64'(regs0), 64'h5A_00_A5_33_00);

        expect_evt(0, K_RD, 32'd8, 32'h33);
        xfer(0, 16, 32'h0100, 1'b0);
        expect_evt(0, K_RD, 32'd8, 32'h5A);
        xfer(0, 16, 32'h0400, 1'b0);

        expect_evt(0, K_RD, 32'd8, 32'h00);
        expect_evt(0, K_ERR, 32'h0, 32'h0);
        xfer(0, 16, 32'h0500, 1'b0);

        for (int i = 0; i < 6; i++) begin
            copi = i[0];
            wait_clk(5);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        wait_clk(10);
        check("ncs_high_idle_regs", 64'(regs0), 64'h5A_00_A5_33_00);

        xfer(0, 12, 32'h8299 >> 4, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        ncs[0] = 1'b1;
        wait_clk(6);
        rst_n = 1'b1;
        wait_clk(6);

        expect_evt(0, K_WR, 32'h10, 32'h07);
        xfer(0, 16, 32'h8407, 1'b0);
        check("post_reset_regs", 64'(regs0), 64'h07_00_00_00_00);

        expect_evt(1, K_WR, 32'h8000, 32'hBEEF);
        xfer(1, 21, 32'h1F_BEEF, 1'b0);
        check("wide_reg15", 64'(regs1[255:240]), 64'hBEEF);
        expect_evt(1, K_RD, 32'd16, 32'hBEEF);
        xfer(1, 21, 32'h0F_0000, 1'b0);
        check("wide_reg15_hold", 64'(regs1[255:240]), 64'hBEEF);

        wait_clk(20);
        check("events_outstanding", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 5: number of writable/readable registers.
REQ-002 Parameter DATA_W, default 8: register and data-field width.
REQ-003 Parameter ADDR_W, default 7: address-field width; frame width FRAME_W = 1 + ADDR_W + DATA_W (16 at defaults).
REQ-004 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 COPI  input  1  serial data in, asynchronous to clk.
REQ-007 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 nCS  input  1  chip select, active-low, asynchronous to clk.
REQ-009 CIPO  output  1  serial read data out.
REQ-010 cipo_oe  output  1  high while a read data phase is active.
REQ-011 regs_out  output  NUM_REGS*DATA_W  flattened register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-012 wr_strobe  output  NUM_REGS  one-clk pulse on bit i when register i is updated.
REQ-013 err_frame  output  1  one-clk pulse on a rejected frame.

Function
REQ-014 COPI, SCLK and nCS SHALL each pass a 3-flop synchronizer; edges SHALL be detected between stages 2 and 3; COPI is sampled from stage 3.
REQ-015 Frame SHALL be MSB first: bit FRAME_W-1 = R/W (1 = write), then ADDR_W address bits, then DATA_W data bits.
REQ-016 States: IDLE, CMD, WR_DATA, RD_DATA, FLUSH; IDLE->CMD on nCS fall; any state->FLUSH on nCS rise; FLUSH->IDLE after one clk.
REQ-017 Bit counter SHALL clear on nCS fall, increment on each SCLK rise while nCS low, and saturate at FRAME_W+1.
REQ-018 CMD->WR_DATA or RD_DATA when counter reaches 1+ADDR_W, per R/W bit.
REQ-019 Write SHALL commit in FLUSH only if counter == FRAME_W and address < NUM_REGS; register update and wr_strobe pulse occur in the same clk.
REQ-020 Read: on entry to RD_DATA, shift register SHALL load regs_out[address] (all zeros if address >= NUM_REGS); cipo_oe asserts.
REQ-021 CIPO SHALL present the data MSB in the clk after RD_DATA entry and shift one bit on each subsequent detected SCLK fall; CIPO = 0 when cipo_oe low.
REQ-022 Reads SHALL never modify registers or pulse wr_strobe.
REQ-023 err_frame SHALL pulse in FLUSH if counter != FRAME_W, or if address >= NUM_REGS.
REQ-024 nCS rise mid-frame SHALL abort without register change; a frame with more than FRAME_W SCLK rises SHALL be rejected.
REQ-025 SCLK and COPI activity while nCS high SHALL be ignored.
REQ-026 Required SCLK high and low times: each >= 4 clk periods; nCS high time: >= 4 clk periods.

Reset
REQ-027 On rst_n low: regs_out = 0, wr_strobe = 0, err_frame = 0, CIPO = 0, cipo_oe = 0, state = IDLE, counter = 0, synchronizers for SCLK/COPI = 0, nCS = 1.
REQ-028 Reset mid-frame SHALL discard the frame; after release the next nCS fall starts a clean frame.

Structure
REQ-029 Package spi_reg_pkg SHALL hold the state enum, the FRAME_W derivation function and the R/W bit encoding constants.
REQ-030 Sub-module spi_sync_edge (3-flop synchronizer plus rise/fall detect, reset value as parameter) SHALL be instantiated once per input.

Verification
REQ-031 Write addr 2 data 0xA5 (frame 0x82A5) -> regs_out[23:16] = 0xA5, wr_strobe = 5'b00100 for one clk, err_frame stays 0.
REQ-032 After REQ-031, read addr 2 (frame 0x0200) -> CIPO bits 1,0,1,0,0,1,0,1 sampled on the last 8 SCLK rises; regs_out unchanged.
REQ-033 Write addr 6 data 0xFF with NUM_REGS = 5 -> no register change, err_frame pulses once.
REQ-034 nCS rises after 10 SCLK rises of frame 0x8133 -> regs_out[15:8] unchanged, err_frame pulses once; 17-rise frame also rejected.
REQ-035 rst_n asserted after 12 bits of a write -> all outputs 0 immediately; subsequent frame 0x8407 -> regs_out[39:32] = 0x07.
REQ-036 Parameter sweep NUM_REGS = 16, DATA_W = 16, ADDR_W = 4 -> write/read round-trip of 0xBEEF to addr 15.
